// File: rtl/vga_sprite_pkg.sv
// Shared types for the VGA sprite engine.
// Contents: RGB332 colour type, rectangle register record, default background.
// Rectangle coordinates are stored at RECT_CW bits, so the engine supports
// COORD_W up to RECT_CW; narrower coordinates are zero-extended on write.
package vga_sprite_pkg;

  localparam int unsigned RECT_CW = 16;

  typedef logic [7:0] rgb332_t;  // {R[2:0],G[2:0],B[1:0]}

  typedef struct packed {
    logic [RECT_CW-1:0] x0;
    logic [RECT_CW-1:0] y0;
    logic [RECT_CW-1:0] w;
    logic [RECT_CW-1:0] h;
    rgb332_t            color;
    logic               en;
  } rect_t;

  localparam rgb332_t BG_COLOR_DEFAULT = 8'h00;

endpackage

// File: rtl/vga_rect_hit.sv
// Combinational hit test of one pixel against one rectangle.
// Ports: rect (active register set), px/py (zero-extended pixel position),
//        hit_c (pixel lies inside an enabled rectangle).
// Right/bottom edges are computed one bit wider than the coordinates, so a
// rectangle running off the screen clips instead of wrapping; w==0 or h==0
// gives an empty range and never hits.
module vga_rect_hit
  import vga_sprite_pkg::*;
(
  input  rect_t                rect,
  input  logic [RECT_CW-1:0]   px,
  input  logic [RECT_CW-1:0]   py,
  output logic                 hit_c
);

  localparam int unsigned SW = RECT_CW + 1;

  logic [SW-1:0] x_end;
  logic [SW-1:0] y_end;

  assign x_end = SW'(rect.x0) + SW'(rect.w);
  assign y_end = SW'(rect.y0) + SW'(rect.h);

  assign hit_c = rect.en &&
                 (px >= rect.x0) && (SW'(px) < x_end) &&
                 (py >= rect.y0) && (SW'(py) < y_end);

endmodule

// File: rtl/vga_sprite_engine.sv
// Rectangle sprite overlay for a VGA pixel stream.
// Optional feature macro: VGA_SPRITE_COLLISION_EN (per-frame overlap flags
// between rectangle 0 and every other rectangle).
// Ports:
//   clk, reset_n              pixel clock, async active-low reset
//   pix_x, pix_y, in_display  position and active-area flag from sync gen
//   hsync_in, vsync_in        raw syncs
//   wr_valid/wr_ready, wr_*   rectangle register write handshake
//   rgb_out                   RGB332 pixel, 2 cycles after pix_x/pix_y
//   hsync_out, vsync_out      syncs delayed to align with rgb_out
//   collision                 per-frame overlap flags (0 unless feature on)
module vga_sprite_engine
  import vga_sprite_pkg::*;
#(
  parameter int unsigned NUM_RECT = 4,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned V_ACTIVE = 480,
  parameter rgb332_t     BG_COLOR = BG_COLOR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [COORD_W-1:0]  pix_x,
  input  logic [COORD_W-1:0]  pix_y,
  input  logic                in_display,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [2:0]          wr_idx,
  input  logic [COORD_W-1:0]  wr_x0,
  input  logic [COORD_W-1:0]  wr_y0,
  input  logic [COORD_W-1:0]  wr_w,
  input  logic [COORD_W-1:0]  wr_h,
  input  logic [7:0]          wr_color,
  input  logic                wr_en,
  output logic [7:0]          rgb_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic [NUM_RECT-1:0] collision
);

  rect_t               shadow_q [NUM_RECT];
  rect_t               active_q [NUM_RECT];
  rect_t               wr_rect_c;
  logic                rdy_q;
  logic                commit_c;
  logic [RECT_CW-1:0]  px_ext;
  logic [RECT_CW-1:0]  py_ext;
  logic [NUM_RECT-1:0] hit_c;
  logic [NUM_RECT-1:0] hit_q;
  logic                disp_q;
  logic                hs_q;
  logic                vs_q;
  rgb332_t             pix_color_c;

  // Commit point: first vertical-blank line, column 0
  assign commit_c = (pix_y == COORD_W'(V_ACTIVE)) && (pix_x == '0);

  // Writes are held off only on the commit cycle so the copy never sees a half-written set
  assign wr_ready = rdy_q && !commit_c;

  assign wr_rect_c = '{x0:    RECT_CW'(wr_x0),
                       y0:    RECT_CW'(wr_y0),
                       w:     RECT_CW'(wr_w),
                       h:     RECT_CW'(wr_h),
                       color: wr_color,
                       en:    wr_en};

  // Shadow/active register sets; out-of-range indices match no entry and are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_RECT; i++) begin
        if (wr_valid && wr_ready && (wr_idx == 3'(i))) shadow_q[i] <= wr_rect_c;
        if (commit_c) active_q[i] <= shadow_q[i];
      end
    end
  end

  assign px_ext = RECT_CW'(pix_x);
  assign py_ext = RECT_CW'(pix_y);

  // One hit comparator per rectangle
  for (genvar g = 0; g < int'(NUM_RECT); g++) begin : g_hit
    vga_rect_hit u_hit (
      .rect  (active_q[g]),
      .px    (px_ext),
      .py    (py_ext),
      .hit_c (hit_c[g])
    );
  end

  // Stage 1: hit vector, display flag, syncs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q  <= '0;
      disp_q <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      hit_q  <= hit_c;
      disp_q <= in_display;
      hs_q   <= hsync_in;
      vs_q   <= vsync_in;
    end
  end

  // Lowest-index hit wins
  always_comb begin
    logic found;
    pix_color_c = BG_COLOR;
    found       = 1'b0;
    for (int unsigned i = 0; i < NUM_RECT; i++) begin
      if (hit_q[i] && !found) begin
        pix_color_c = active_q[i].color;
        found       = 1'b1;
      end
    end
  end

  // Stage 2: pixel colour and aligned syncs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out   <= 8'h00;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb_out   <= disp_q ? pix_color_c : 8'h00;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
    end
  end

`ifdef VGA_SPRITE_COLLISION_EN
  logic [NUM_RECT-1:0] coll_acc_q;
  logic [NUM_RECT-1:0] coll_new_c;

  // Overlaps of rectangle 0 with rectangle i on a visible pixel; bit 0 stays clear
  always_comb begin
    coll_new_c = '0;
    for (int unsigned i = 1; i < NUM_RECT; i++) begin
      coll_new_c[i] = in_display && hit_c[0] && hit_c[i];
    end
  end

  // Accumulate over the frame, publish and clear on commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_acc_q <= '0;
      collision  <= '0;
    end else if (commit_c) begin
      collision  <= coll_acc_q;
      coll_acc_q <= '0;
    end else begin
      coll_acc_q <= coll_acc_q | coll_new_c;
    end
  end
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed self-checking bench for vga_sprite_engine (NUM_RECT=4, BG=8'h25).
module tb_vga_sprite_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pix_x, pix_y;
  logic       in_display, hsync_in, vsync_in;
  logic       wr_valid, wr_ready;
  logic [2:0] wr_idx;
  logic [9:0] wr_x0, wr_y0, wr_w, wr_h;
  logic [7:0] wr_color;
  logic       wr_en;
  logic [7:0] rgb_out;
  logic       hsync_out, vsync_out;
  logic [3:0] collision;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef VGA_SPRITE_COLLISION_EN
  localparam logic [3:0] EXP_COLL = 4'b0100;
`else
  localparam logic [3:0] EXP_COLL = 4'b0000;
`endif
  localparam logic [7:0] BG = 8'h25;

  always #5 clk = ~clk;

  vga_sprite_engine #(
    .NUM_RECT (4),
    .COORD_W  (10),
    .V_ACTIVE (480),
    .BG_COLOR (8'h25)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .in_display (in_display),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_x0      (wr_x0),
    .wr_y0      (wr_y0),
    .wr_w       (wr_w),
    .wr_h       (wr_h),
    .wr_color   (wr_color),
    .wr_en      (wr_en),
    .rgb_out    (rgb_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .collision  (collision)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y,
                         input logic d, input logic hs, input logic vs);
    pix_x      = x;
    pix_y      = y;
    in_display = d;
    hsync_in   = hs;
    vsync_in   = vs;
  endtask

  // Hold a visible pixel for two clocks, then compare the colour
  task automatic check_pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [7:0] exp);
    set_pix(x, y, 1'b1, 1'b0, 1'b0);
    step();
    step();
    chk(tag, rgb_out, exp);
  endtask

  // Pass through the commit point (line 480, column 0) for one clock
  task automatic commit();
    set_pix(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
    #1;
    chk("commit_rdy_low", wr_ready, 1'b0);
    step();
    set_pix(10'd1, 10'd480, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic write_rect(input logic [2:0] idx, input logic [9:0] x0, input logic [9:0] y0,
                            input logic [9:0] w, input logic [9:0] h,
                            input logic [7:0] c, input logic en);
    wr_idx   = idx;
    wr_x0    = x0;
    wr_y0    = y0;
    wr_w     = w;
    wr_h     = h;
    wr_color = c;
    wr_en    = en;
    wr_valid = 1'b1;
    #1;
    chk("wr_ready_high", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_idx   = '0;
    wr_x0    = '0;
    wr_y0    = '0;
    wr_w     = '0;
    wr_h     = '0;
    wr_color = '0;
    wr_en    = 1'b0;
    set_pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);

    // Reset state
    step(); step(); step();
    chk("rst_rgb",   rgb_out,   8'h00);
    chk("rst_hs",    hsync_out, 1'b0);
    chk("rst_vs",    vsync_out, 1'b0);
    chk("rst_coll",  collision, 4'b0000);
    chk("rst_ready", wr_ready,  1'b0);
    set_pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    chk("ready_after_rst", wr_ready, 1'b1);

    // Single rectangle: invisible until commit, then inclusive/exclusive edges
    write_rect(3'd0, 10'd100, 10'd100, 10'd101, 10'd101, 8'hFF, 1'b1);
    check_pix("precommit_100", 10'd100, 10'd100, BG);
    commit();
    check_pix("r0_100_100", 10'd100, 10'd100, 8'hFF);
    check_pix("r0_200_200", 10'd200, 10'd200, 8'hFF);
    check_pix("r0_201_200", 10'd201, 10'd200, BG);
    check_pix("r0_200_201", 10'd200, 10'd201, BG);
    check_pix("r0_99_100",  10'd99,  10'd100, BG);
    set_pix(10'd150, 10'd150, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("blank_black", rgb_out, 8'h00);

    // Exact two-cycle latency for colour and syncs
    set_pix(10'd150, 10'd150, 1'b1, 1'b1, 1'b0);
    step();
    chk("lat_hs_early", hsync_out, 1'b0);
    set_pix(10'd10, 10'd10, 1'b1, 1'b0, 1'b1);
    step();
    chk("lat_rgb_a", rgb_out,   8'hFF);
    chk("lat_hs_a",  hsync_out, 1'b1);
    chk("lat_vs_a",  vsync_out, 1'b0);
    step();
    chk("lat_rgb_b", rgb_out,   BG);
    chk("lat_hs_b",  hsync_out, 1'b0);
    chk("lat_vs_b",  vsync_out, 1'b1);

    // Overlap priority; repeated write to idx1 keeps the last value
    write_rect(3'd0, 10'd100, 10'd100, 10'd50, 10'd50, 8'hE0, 1'b1);
    write_rect(3'd1, 10'd120, 10'd120, 10'd50, 10'd50, 8'h03, 1'b1);
    write_rect(3'd1, 10'd120, 10'd120, 10'd50, 10'd50, 8'h1C, 1'b1);
    commit();
    check_pix("ovl_130", 10'd130, 10'd130, 8'hE0);
    check_pix("ovl_110", 10'd110, 10'd110, 8'hE0);
    check_pix("ovl_160", 10'd160, 10'd160, 8'h1C);
    check_pix("ovl_100_160", 10'd100, 10'd160, BG);

    // wr_valid held across the commit cycle
    wr_idx = 3'd2; wr_x0 = 10'd300; wr_y0 = 10'd300; wr_w = 10'd10; wr_h = 10'd10;
    wr_color = 8'h03; wr_en = 1'b1; wr_valid = 1'b1;
    commit();
    chk("held_ready_after", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
    check_pix("held_not_yet", 10'd305, 10'd305, BG);
    commit();
    check_pix("held_visible", 10'd305, 10'd305, 8'h03);
    check_pix("held_r0_kept", 10'd130, 10'd130, 8'hE0);

    // Zero width and out-of-range index: accepted, nothing drawn
    write_rect(3'd3, 10'd400, 10'd400, 10'd0, 10'd10, 8'hFC, 1'b1);
    write_rect(3'd7, 10'd0, 10'd0, 10'd640, 10'd480, 8'hFF, 1'b1);
    commit();
    check_pix("w0_400",   10'd400, 10'd400, BG);
    check_pix("idx7_10",  10'd10,  10'd10,  BG);
    check_pix("keep_r0",  10'd130, 10'd130, 8'hE0);
    check_pix("keep_r2",  10'd305, 10'd305, 8'h03);

    // Collision: rect0 overlaps rect2 only, then rect2 moves away
    write_rect(3'd1, 10'd120, 10'd120, 10'd50, 10'd50, 8'h1C, 1'b0);
    write_rect(3'd2, 10'd110, 10'd110, 10'd10, 10'd10, 8'h03, 1'b1);
    commit();
    check_pix("coll_pix", 10'd115, 10'd115, 8'hE0);
    write_rect(3'd2, 10'd300, 10'd300, 10'd10, 10'd10, 8'h03, 1'b1);
    commit();
    chk("coll_set", collision, EXP_COLL);
    check_pix("coll_r0_only", 10'd115, 10'd115, 8'hE0);
    check_pix("coll_r2_moved", 10'd305, 10'd305, 8'h03);
    commit();
    chk("coll_clear", collision, 4'b0000);

    // Mid-frame reset: outputs clear at once, pending write discarded
    write_rect(3'd3, 10'd0, 10'd0, 10'd640, 10'd480, 8'hFF, 1'b1);
    set_pix(10'd130, 10'd130, 1'b1, 1'b1, 1'b1);
    step(); step();
    chk("pre_rst_rgb", rgb_out, 8'hE0);
    reset_n = 1'b0;
    #1;
    chk("midrst_rgb",   rgb_out,   8'h00);
    chk("midrst_hs",    hsync_out, 1'b0);
    chk("midrst_vs",    vsync_out, 1'b0);
    chk("midrst_ready", wr_ready,  1'b0);
    chk("midrst_coll",  collision, 4'b0000);
    set_pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    commit();
    check_pix("postrst_130", 10'd130, 10'd130, BG);
    check_pix("postrst_10",  10'd10,  10'd10,  BG);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  - NUM_RECT, 4, rectangle count (1..8)
  - COORD_W, 10, pixel coordinate width
  - V_ACTIVE, 480, first vertical-blank line
  - BG_COLOR, 8'h00, RGB332 background
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1, pixel clock
  - reset_n, in, 1, asynchronous active-low reset
  - pix_x, in, COORD_W, current column from sync generator
  - pix_y, in, COORD_W, current row from sync generator
  - in_display, in, 1, active-area flag
  - hsync_in, in, 1, raw horizontal sync
  - vsync_in, in, 1, raw vertical sync
  - wr_valid, in, 1, register-write request
  - wr_ready, out, 1, write accepted when both high
  - wr_idx, in, 3, target rectangle
  - wr_x0, in, COORD_W, left edge
  - wr_y0, in, COORD_W, top edge
  - wr_w, in, COORD_W, width
  - wr_h, in, COORD_W, height
  - wr_color, in, 8, RGB332 colour
  - wr_en, in, 1, rectangle visible
  - rgb_out, out, 8, {R[2:0],G[2:0],B[1:0]}
  - hsync_out, out, 1, sync delayed to align with rgb_out
  - vsync_out, out, 1, sync delayed to align with rgb_out
  - collision, out, NUM_RECT, per-frame overlap flags

Function
REQ-003 Each rectangle SHALL hold a shadow register set (written by the handshake) and an active set (used for drawing).
REQ-004 A write SHALL complete on a clk edge with wr_valid && wr_ready, loading the shadow set selected by wr_idx.
REQ-005 Writes with wr_idx >= NUM_RECT SHALL be accepted and discarded.
REQ-006 Multiple writes to one index within a frame SHALL leave the last value.
REQ-007 A commit pulse SHALL fire for one cycle when pix_y == V_ACTIVE and pix_x == 0, copying every shadow set to its active set.
REQ-008 wr_ready SHALL be 0 on the commit cycle and 1 at all other times out of reset; a write is therefore never lost or torn by a commit.
REQ-009 Rectangle i SHALL hit when enabled && x0 <= pix_x < x0+w && y0 <= pix_y < y0+h, with sums evaluated at COORD_W+1 bits (no wrap).
REQ-010 A rectangle with w == 0 or h == 0 SHALL never hit; rectangles extending past the screen edge SHALL be clipped naturally.
REQ-011 The pipeline SHALL have two stages:
  - stage 1 registers the hit vector, in_display and syncs;
  - stage 2 registers rgb_out.
REQ-012 Latency from pix_x/pix_y to rgb_out, hsync_out and vsync_out SHALL be exactly 2 clk cycles.
REQ-013 rgb_out SHALL be:
  - the colour of the lowest-index hit rectangle;
  - BG_COLOR when nothing hits;
  - 8'h00 whenever the delayed in_display is 0.
REQ-014 Active sets SHALL change only on a commit, so a frame is never drawn from mixed register states.

Reset
REQ-015 While reset_n is low, all of the following SHALL be cleared asynchronously:
  - shadow and active sets, including enable bits;
  - pipeline registers;
  - rgb_out = 0, hsync_out = 0, vsync_out = 0, collision = 0;
  - wr_ready = 0.
REQ-016 The first commit after reset_n deasserts SHALL occur at the next line-V_ACTIVE/column-0 point.
REQ-017 Reset mid-frame SHALL discard pending shadow writes.

Configuration
REQ-018 With VGA_SPRITE_COLLISION_EN defined:
  - an internal accumulator SHALL set bit i (i >= 1) when rectangles 0 and i hit on the same in-display pixel;
  - on each commit, collision SHALL be loaded from the accumulator and the accumulator cleared;
  - bit 0 SHALL always be 0.
REQ-019 Without VGA_SPRITE_COLLISION_EN, collision SHALL be tied to 0 and no accumulator logic SHALL exist.

Structure
REQ-020 A shared package vga_sprite_pkg SHALL hold:
  - the RGB332 colour type;
  - the rect_t record {x0, y0, w, h, color, en};
  - the BG_COLOR default.
REQ-021 Per-rectangle hit comparison SHALL be a sub-module, vga_rect_hit, instanced NUM_RECT times.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Reset, then write idx0 {x0=100, y0=100, w=101, h=101, color=8'hFF, en=1} -> no change until commit; next frame rgb_out=8'hFF at (100,100) and (200,200) two cycles later, BG at (201,200).
  - idx0 and idx1 overlap, colours 8'hE0 and 8'h1C -> overlap pixels show 8'hE0 (lowest index wins).
  - wr_valid held high across the commit cycle -> wr_ready low for exactly that cycle, write completes the next cycle and takes effect one frame later.
  - w=0, or wr_idx=7 with NUM_RECT=4 -> write accepted, nothing drawn, other rectangles unchanged.
  - COLLISION_EN, rect0 overlapping rect2 only -> collision=4'b0100 after commit; move rect2 away -> 4'b0000 the following frame.
  - reset_n pulsed low mid-frame -> outputs 0 immediately, all rectangles disabled afterwards.
